pm_entry_req_tx: RTL and testbench
==================================

Name: pm_entry_req_tx

Overview:
- Parametrised PM-entry requester on the RDI sideband path.
- On enable, it waits for the local responder (rx side) to release the sideband, then sends an L1 or L2 request message and waits for the partner's response.
- A timeout limit applies, selected by clock-mode; on timeout it retries up to a configured count, then reports the outcome (success / NAK / timeout) to the RDI FSM.
- Successor to the fixed L1/L2 entry transmitter: adds retry, a sticky timeout flag, a retry counter output and parametrised widths and limits.

Parameters:
- MSG_W, 4, sideband message-number width.
- CNT_W, 10, timeout counter width; must hold max(TMO_SLOW, TMO_FAST).
- TMO_SLOW, 200, timeout in cycles when i_clk_div_ratio=0 (2 us at 100 MHz).
- TMO_FAST, 400, timeout in cycles when i_clk_div_ratio=1 (2 us at 200 MHz).
- MAX_RETRY, 2, number of re-sends after the first attempt times out.
- RTY_W, 2, retry counter width; must hold MAX_RETRY.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  flow enable from RDI FSM; deassertion aborts.
- i_req_l2  in  1  0: request L1, 1: request L2; sampled on the IDLE exit.
- i_clk_div_ratio  in  1  selects TMO_SLOW(0) or TMO_FAST(1).
- i_rx_msg_valid  in  1  rx responder currently owns the sideband.
- i_msg_valid  in  1  received sideband message valid.
- i_msg_no  in  MSG_W  received message number.
- i_msg_done  in  1  sideband finished sending the current message.
- o_msg_valid  out  1  request message valid.
- o_msg_no  out  MSG_W  request message number.
- o_test_done  out  1  flow complete.
- o_pm_nak  out  1  1: entry failed (NAK, mismatch or timeout).
- o_timeout  out  1  failure caused by retry exhaustion.
- o_retry_cnt  out  RTY_W  retries consumed.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- States: IDLE, WAIT_RX, SEND_REQ, WAIT_RSP, DONE. Every output is registered.
- i_en=0 in any state: next state is IDLE. IDLE clears all outputs and counters one cycle later.
- IDLE with i_en=1:
  - latch i_req_l2 into the request code (L1=2, L2=3);
  - go to WAIT_RX if i_rx_msg_valid=1, else SEND_REQ.
- WAIT_RX: stay while i_rx_msg_valid=1; otherwise go to SEND_REQ.
- SEND_REQ:
  - o_msg_valid=1 and o_msg_no=request code, set in the cycle the state is entered;
  - on i_msg_done && !i_rx_msg_valid: o_msg_valid goes to 0 next cycle, timeout counter clears, go to WAIT_RSP;
  - i_msg_done while i_rx_msg_valid=1 is ignored, because that done belongs to the rx side.
- Response evaluation, in SEND_REQ or WAIT_RSP, when i_msg_valid=1:
  - matching response (Rsp_L1=10 for an L1 request, Rsp_L2=11 for an L2 request): go to DONE with pm_nak=0;
  - PMNAK=9 or the opposite Rsp: go to DONE with pm_nak=1;
  - any other code is ignored.
- WAIT_RSP timeout:
  - counter increments by 1 each cycle;
  - on counter == limit-1 with retry_cnt < MAX_RETRY: retry_cnt++, then go to WAIT_RX or SEND_REQ by the same rule as IDLE;
  - on counter == limit-1 with retry_cnt == MAX_RETRY: go to DONE with pm_nak=1, timeout=1.
- Limit is re-evaluated every cycle from i_clk_div_ratio. If the counter already exceeds a newly selected smaller limit, treat it as expired.
- Response and timeout expiry in the same cycle: the response wins.
- DONE: o_test_done=1, and o_pm_nak/o_timeout hold until i_en=0. Further sideband messages are ignored.
- Counter saturates; it never wraps.

Optional Feature:
- Macro: PM_ENTRY_L2_EN.
- Defined: L2 requests are supported as above.
- Undefined: i_req_l2 is ignored and an L1 request is always sent; Rsp_L2 is treated as a mismatch (pm_nak=1).

Decomposition:
- Package pm_entry_pkg: message-code constants (Req_L1=2, Req_L2=3, PMNAK=9, Rsp_L1=10, Rsp_L2=11) and the state enum encoding.
- One natural sub-module: pm_tmo_counter (clear, enable, limit select, expire pulse).

Test Plan:
- L1 success: en=1, rx idle, msg_done at cycle 3, then i_msg_no=10 valid -> o_msg_no=2 pulse window, o_test_done=1, o_pm_nak=0, o_retry_cnt=0.
- L2 with NAK: i_req_l2=1, i_msg_no=9 -> o_msg_no=3, done=1, pm_nak=1, timeout=0.
- Rx priority: i_rx_msg_valid=1 for 20 cycles with i_msg_done pulses -> o_msg_valid stays 0, then asserts 1 cycle after rx releases; rx done pulses do not clear it.
- Timeout/retry: no response, div_ratio=0 -> exactly 3 requests sent 200 cycles apart (after done), then done=1, pm_nak=1, timeout=1, retry_cnt=2.
- Collision: Rsp_L1 in the same cycle as the final expiry -> pm_nak=0, timeout=0.
- Abort: i_en drops in WAIT_RSP at count 150 -> IDLE; all outputs 0 the following cycle; a re-enable restarts with retry_cnt=0.

Source files
------------

// File: rtl/pm_entry_req_tx_pkg.sv
`default_nettype none
// pm_entry_pkg: sideband message codes, FSM state encoding and response classification
// shared by the PM-entry requester.
package pm_entry_pkg;

    localparam int unsigned MSG_REQ_L1 = 2;
    localparam int unsigned MSG_REQ_L2 = 3;
    localparam int unsigned MSG_PMNAK  = 9;
    localparam int unsigned MSG_RSP_L1 = 10;
    localparam int unsigned MSG_RSP_L2 = 11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RX  = 3'd1,
        ST_SEND_REQ = 3'd2,
        ST_WAIT_RSP = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_ACK  = 2'd1,
        RSP_NAK  = 2'd2
    } rsp_e;

    function automatic int unsigned req_code(input logic is_l2);
        return is_l2 ? MSG_REQ_L2 : MSG_REQ_L1;
    endfunction

    // The opposite Rsp counts as a refusal; codes outside the response set are ignored.
    function automatic rsp_e classify_rsp(input logic is_l2, input int unsigned code);
        int unsigned want;
        want = is_l2 ? MSG_RSP_L2 : MSG_RSP_L1;
        if (code == want)
            return RSP_ACK;
        if ((code == MSG_PMNAK) || (code == MSG_RSP_L1) || (code == MSG_RSP_L2))
            return RSP_NAK;
        return RSP_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pm_entry_req_tx_tmo_counter.sv
`default_nettype none
// pm_tmo_counter: saturating response-timeout counter; the limit is chosen each cycle
// from the clock-mode select and expire flags the last cycle of the window.
module pm_tmo_counter #(
    parameter int CNT_W    = 10,
    parameter int TMO_SLOW = 200,
    parameter int TMO_FAST = 400
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic sel_fast,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(TMO_SLOW - 1);
    localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(TMO_FAST - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && (count != '1))
            count <= count + CNT_W'(1);
    end

    assign last = sel_fast ? LAST_FAST : LAST_SLOW;
    // >= so that switching to the shorter limit mid-wait still expires
    assign expire = (count >= last);

endmodule
`default_nettype wire

// File: rtl/pm_entry_req_tx.sv
`default_nettype none
// pm_entry_req_tx: PM-entry (L1/L2) requester on the RDI sideband with timeout retry.
// L2 requests are supported only when the macro PM_ENTRY_L2_EN is defined.
module pm_entry_req_tx
    import pm_entry_pkg::*;
#(
    parameter int MSG_W     = 4,
    parameter int CNT_W     = 10,
    parameter int TMO_SLOW  = 200,
    parameter int TMO_FAST  = 400,
    parameter int MAX_RETRY = 2,
    parameter int RTY_W     = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_req_l2,
    input  logic             i_clk_div_ratio,
    input  logic             i_rx_msg_valid,
    input  logic             i_msg_valid,
    input  logic [MSG_W-1:0] i_msg_no,
    input  logic             i_msg_done,
    output logic             o_msg_valid,
    output logic [MSG_W-1:0] o_msg_no,
    output logic             o_test_done,
    output logic             o_pm_nak,
    output logic             o_timeout,
    output logic [RTY_W-1:0] o_retry_cnt
);

`ifdef PM_ENTRY_L2_EN
    localparam logic L2_EN = 1'b1;
`else
    localparam logic L2_EN = 1'b0;
`endif

    state_e           state, state_n;
    logic             req_l2, req_l2_n;
    logic [RTY_W-1:0] retry_n;
    logic             nak_n, tmo_n;
    logic             send_done;
    logic             tmo_clr, tmo_en, tmo_expire;
    rsp_e             rsp;

    // A done seen while rx owns the sideband belongs to the rx message, not ours.
    assign send_done = (state == ST_SEND_REQ) && i_msg_done && !i_rx_msg_valid;
    assign tmo_clr   = !i_en || (state == ST_IDLE) || send_done;
    assign tmo_en    = (state == ST_WAIT_RSP);
    assign rsp       = i_msg_valid ? classify_rsp(req_l2, 32'(i_msg_no)) : RSP_NONE;

    pm_tmo_counter #(
        .CNT_W    (CNT_W),
        .TMO_SLOW (TMO_SLOW),
        .TMO_FAST (TMO_FAST)
    ) u_tmo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .clr      (tmo_clr),
        .en       (tmo_en),
        .sel_fast (i_clk_div_ratio),
        .expire   (tmo_expire)
    );

    always_comb begin
        state_n  = state;
        req_l2_n = req_l2;
        retry_n  = o_retry_cnt;
        nak_n    = o_pm_nak;
        tmo_n    = o_timeout;
        if (!i_en) begin
            state_n  = ST_IDLE;
            req_l2_n = 1'b0;
            retry_n  = '0;
            nak_n    = 1'b0;
            tmo_n    = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_l2_n = L2_EN & i_req_l2;
                    retry_n  = '0;
                    nak_n    = 1'b0;
                    tmo_n    = 1'b0;
                    state_n  = i_rx_msg_valid ? ST_WAIT_RX : ST_SEND_REQ;
                end
                ST_WAIT_RX: begin
                    if (!i_rx_msg_valid)
                        state_n = ST_SEND_REQ;
                end
                ST_SEND_REQ: begin
                    if (rsp != RSP_NONE) begin
                        state_n = ST_DONE;
                        nak_n   = (rsp == RSP_NAK);
                    end else if (send_done) begin
                        state_n = ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    // A response arriving on the expiry cycle takes precedence.
                    if (rsp != RSP_NONE) begin
                        state_n = ST_DONE;
                        nak_n   = (rsp == RSP_NAK);
                    end else if (tmo_expire) begin
                        if (o_retry_cnt < RTY_W'(MAX_RETRY)) begin
                            retry_n = o_retry_cnt + RTY_W'(1);
                            state_n = i_rx_msg_valid ? ST_WAIT_RX : ST_SEND_REQ;
                        end else begin
                            state_n = ST_DONE;
                            nak_n   = 1'b1;
                            tmo_n   = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_n = ST_DONE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            req_l2      <= 1'b0;
            o_msg_valid <= 1'b0;
            o_msg_no    <= '0;
            o_test_done <= 1'b0;
            o_pm_nak    <= 1'b0;
            o_timeout   <= 1'b0;
            o_retry_cnt <= '0;
        end else begin
            state       <= state_n;
            req_l2      <= req_l2_n;
            o_msg_valid <= (state_n == ST_SEND_REQ);
            o_msg_no    <= (state_n == ST_SEND_REQ) ? MSG_W'(req_code(req_l2_n)) : '0;
            o_test_done <= (state_n == ST_DONE);
            o_pm_nak    <= nak_n;
            o_timeout   <= tmo_n;
            o_retry_cnt <= retry_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pm_entry_req_tx.sv
`default_nettype none
// tb_pm_entry_req_tx: scoreboard bench for pm_entry_req_tx; expected requests/outcomes are
// derived from flow parameters and checked by an independent output monitor.
module tb_pm_entry_req_tx;

    localparam int MAX_RETRY = 2;
    localparam int TMO_SLOW  = 200;
    localparam int TMO_FAST  = 400;
    localparam int BOUND     = 1500;
`ifdef PM_ENTRY_L2_EN
    localparam bit L2_EN = 1'b1;
`else
    localparam bit L2_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       req_l2 = 1'b0;
    logic       ratio = 1'b0;
    logic       rx = 1'b0;
    logic       msg_valid = 1'b0;
    logic [3:0] msg_no = 4'd0;
    logic       msg_done = 1'b0;
    logic       o_msg_valid;
    logic [3:0] o_msg_no;
    logic       o_test_done;
    logic       o_pm_nak;
    logic       o_timeout;
    logic [1:0] o_retry_cnt;

    pm_entry_req_tx dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_en            (en),
        .i_req_l2        (req_l2),
        .i_clk_div_ratio (ratio),
        .i_rx_msg_valid  (rx),
        .i_msg_valid     (msg_valid),
        .i_msg_no        (msg_no),
        .i_msg_done      (msg_done),
        .o_msg_valid     (o_msg_valid),
        .o_msg_no        (o_msg_no),
        .o_test_done     (o_test_done),
        .o_pm_nak        (o_pm_nak),
        .o_timeout       (o_timeout),
        .o_retry_cnt     (o_retry_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int code; int gap; } req_exp_t;
    typedef struct { int nak; int tmo; int retry; } res_exp_t;

    req_exp_t req_q[$];
    res_exp_t res_q[$];
    int       ref_cyc = 0;
    int       n_checks = 0;
    int       n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every new request or completion pops the oldest expectation.
    bit prev_mv = 1'b0;
    bit prev_td = 1'b0;
    initial begin
        req_exp_t re;
        res_exp_t se;
        forever begin
            @(posedge clk);
            #1;
            if (o_msg_valid && !prev_mv) begin
                if (req_q.size() == 0) begin
                    check("unexpected_request", 1, 0);
                end else begin
                    re = req_q.pop_front();
                    check("req_msg_no", int'(o_msg_no), re.code);
                    check("req_gap", cyc - ref_cyc, re.gap);
                end
            end
            if (o_test_done && !prev_td) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    se = res_q.pop_front();
                    check("res_pm_nak", int'(o_pm_nak), se.nak);
                    check("res_timeout", int'(o_timeout), se.tmo);
                    check("res_retry_cnt", int'(o_retry_cnt), se.retry);
                end
            end
            prev_mv = o_msg_valid;
            prev_td = o_test_done;
        end
    end

    task automatic wait_sig(input bit want_done, output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (!(want_done ? o_test_done : o_msg_valid)) begin
            @(negedge clk);
            n++;
            if (n > BOUND) begin
                check(want_done ? "wait_done_bound" : "wait_req_bound", 0, 1);
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic bail_out();
        en = 1'b0;
        repeat (3) @(negedge clk);
        req_q.delete();
        res_q.delete();
    endtask

    task automatic check_idle(input string name);
        check(name, int'({o_msg_valid, o_msg_no, o_test_done, o_pm_nak, o_timeout, o_retry_cnt}), 0);
    endtask

    // One full flow: ntmo attempts time out before the response (ntmo > MAX_RETRY: never answered).
    // delay = cycles after the accepted done until the response is sampled.
    task automatic run_flow(input bit l2, input int rx_cyc, input int ntmo, input int rsp,
                            input bit rat, input int delay);
        bit       eff;
        int       code, lim, nreq, exp_retry;
        bit       tout, exp_nak, ok;
        req_exp_t r;
        res_exp_t s;
        eff       = L2_EN && l2;
        code      = eff ? 3 : 2;
        lim       = rat ? TMO_FAST : TMO_SLOW;
        tout      = (ntmo > MAX_RETRY);
        nreq      = tout ? MAX_RETRY + 1 : ntmo + 1;
        exp_nak   = tout ? 1'b1 : (rsp != (eff ? 11 : 10));
        exp_retry = tout ? MAX_RETRY : ntmo;
        for (int i = 0; i < nreq; i++) begin
            r.code = code;
            r.gap  = (i == 0) ? 1 : lim;
            req_q.push_back(r);
        end
        s.nak = exp_nak; s.tmo = tout; s.retry = exp_retry;
        res_q.push_back(s);

        @(negedge clk);
        ratio = rat; req_l2 = l2; rx = (rx_cyc > 0); en = 1'b1; ref_cyc = cyc;
        if (rx_cyc > 0) begin
            for (int i = 0; i < rx_cyc; i++) begin
                @(negedge clk);
                msg_done = 1'($urandom_range(0, 1));
            end
            msg_done = 1'b0; rx = 1'b0; ref_cyc = cyc;
        end
        for (int a = 0; a < nreq; a++) begin
            wait_sig(1'b0, ok);
            if (!ok) begin bail_out(); return; end
            req_l2 = 1'($urandom_range(0, 1));
            if (a == 0 && rx_cyc > 0) begin
                rx = 1'b1; msg_done = 1'b1;
                @(negedge clk);
                rx = 1'b0; msg_done = 1'b0;
                @(negedge clk);
                check("rx_done_ignored", int'(o_msg_valid), 1);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            msg_done = 1'b1; ref_cyc = cyc + 1;
            @(negedge clk);
            msg_done = 1'b0;
            if (a == nreq - 1 && !tout) begin
                if (delay >= 3) begin
                    msg_no = 4'($urandom_range(0, 8)); msg_valid = 1'b1;
                    @(negedge clk);
                    msg_valid = 1'b0;
                end
                while (cyc < ref_cyc + delay - 1) @(negedge clk);
                msg_no = 4'(rsp); msg_valid = 1'b1;
                @(negedge clk);
                msg_valid = 1'b0;
            end
        end
        wait_sig(1'b1, ok);
        if (!ok) begin bail_out(); return; end
        msg_no = exp_nak ? 4'd10 : 4'd9; msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        @(negedge clk);
        check("done_sticky", int'(o_test_done), 1);
        check("nak_sticky", int'(o_pm_nak), int'(exp_nak));
        check("timeout_sticky", int'(o_timeout), int'(tout));
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle("idle_after_flow");
    endtask

    initial begin
        bit       ok, rat, l2;
        int       lim, ntmo, rx_cyc;
        req_exp_t r;

        repeat (3) @(negedge clk);
        check("rst_msg_valid", int'(o_msg_valid), 0);
        check("rst_msg_no", int'(o_msg_no), 0);
        check("rst_test_done", int'(o_test_done), 0);
        check("rst_pm_nak", int'(o_pm_nak), 0);
        check("rst_timeout", int'(o_timeout), 0);
        check("rst_retry_cnt", int'(o_retry_cnt), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_flow(1'b0, 0, 0, 10, 1'b0, 3);              // L1 success
        run_flow(1'b1, 0, 0, 9, 1'b0, 4);               // L2 request answered by PMNAK
        run_flow(1'b0, 20, 0, 10, 1'b0, 5);             // rx holds the sideband first
        run_flow(1'b0, 0, MAX_RETRY + 1, 10, 1'b0, 1);  // retries exhausted
        run_flow(1'b0, 0, MAX_RETRY, 10, 1'b0, TMO_SLOW); // response on the final expiry cycle
        run_flow(1'b1, 0, 1, 11, 1'b1, TMO_FAST);       // fast limit, response on retry expiry edge

        // Abort during the second attempt's wait, then a clean restart.
        r.code = 2; r.gap = 1;        req_q.push_back(r);
        r.code = 2; r.gap = TMO_SLOW; req_q.push_back(r);
        @(negedge clk);
        ratio = 1'b0; req_l2 = 1'b0; rx = 1'b0; en = 1'b1; ref_cyc = cyc;
        for (int a = 0; a < 2; a++) begin
            wait_sig(1'b0, ok);
            if (!ok) break;
            msg_done = 1'b1; ref_cyc = cyc + 1;
            @(negedge clk);
            msg_done = 1'b0;
        end
        while (cyc < ref_cyc + 150) @(negedge clk);
        check("abort_retry_cnt", int'(o_retry_cnt), 1);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle("idle_after_abort");
        run_flow(1'b0, 0, 0, 10, 1'b0, 6);

        for (int k = 0; k < 12; k++) begin
            rat    = 1'($urandom_range(0, 1));
            l2     = 1'($urandom_range(0, 1));
            lim    = rat ? TMO_FAST : TMO_SLOW;
            ntmo   = $urandom_range(0, MAX_RETRY + 1);
            rx_cyc = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
            run_flow(l2, rx_cyc, ntmo, 9 + $urandom_range(0, 2), rat, $urandom_range(1, lim));
        end

        repeat (3) @(negedge clk);
        check("req_queue_drained", req_q.size(), 0);
        check("res_queue_drained", res_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
